// File: rtl/burst_ram.sv
// Single-port synchronous RAM with a wrap-around burst engine and clear-on-reset.
// Optional feature: define BURST_RAM_PARITY_EN to store and check one even-parity bit per word.
module burst_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cs,
    input  logic              re,
    input  logic              we,
    input  logic              start,
    input  logic [ADDR_W-1:0] adress,
    input  logic [ADDR_W:0]   burst_len,
    input  logic [DATA_W-1:0] in,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              busy,
    output logic              done,
    output logic              parity_err
);

    // state | meaning
    // IDLE  | single accesses on cs; a start with nonzero length launches a burst
    // BURST | one beat per clock at ptr, cnt beats remaining, dir 1=write 0=read
    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int                DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W + 1)'(1);

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W:0]     cnt;
    logic                dir;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic                start_ok;
    logic                last_beat;
    logic                wr_en;
    logic                rd_en;
    logic [ADDR_W-1:0]   acc_addr;
    logic [ADDR_W:0]     len_clamped;

    assign start_ok    = cs && start && (burst_len != '0);
    assign last_beat   = (cnt == ONE_L);
    assign len_clamped = (burst_len > DEPTH_L) ? DEPTH_L : burst_len;
    assign busy        = (state == BURST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        acc_addr  = adress;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = BURST;
                end else if (cs) begin
                    // write wins when both enables are set
                    wr_en = we;
                    rd_en = re && !we;
                end
            end
            BURST: begin
                acc_addr = ptr;
                wr_en    = dir;
                rd_en    = !dir;
                if (last_beat) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            out       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            ptr       <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
        end else begin
            out_valid <= rd_en;
            done      <= (state == BURST) && last_beat;
            if (wr_en) begin
                mem[acc_addr] <= in;
            end
            if (rd_en) begin
                out <= mem[acc_addr];
            end
            if (state == IDLE) begin
                if (start_ok) begin
                    ptr <= adress;
                    cnt <= len_clamped;
                    dir <= we;
                end
            end else begin
                ptr <= ptr + ADDR_W'(1);
                cnt <= cnt - ONE_L;
            end
        end
    end

`ifdef BURST_RAM_PARITY_EN
    // all-zero words after reset carry a matching zero parity bit
    logic par [DEPTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                par[i] <= 1'b0;
            end
            parity_err <= 1'b0;
        end else begin
            if (wr_en) begin
                par[acc_addr] <= ^in;
            end
            parity_err <= rd_en && ((^mem[acc_addr]) != par[acc_addr]);
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_ram.sv
// Directed self-checking bench for burst_ram: reset clear, single access, bursts, clamp, abort.
module tb_burst_ram;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       cs;
    logic       re;
    logic       we;
    logic       start;
    logic [2:0] adress;
    logic [3:0] burst_len;
    logic [7:0] in;
    logic [7:0] out;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic       parity_err;

    logic [7:0] model [DEPTH];
    int         n_chk  = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    burst_ram #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .cs         (cs),
        .re         (re),
        .we         (we),
        .start      (start),
        .adress     (adress),
        .burst_len  (burst_len),
        .in         (in),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done),
        .parity_err (parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; re = 1'b0; we = 1'b0; start = 1'b0;
    endtask

    task automatic single_write(input logic [2:0] a, input logic [7:0] d);
        cs = 1'b1; we = 1'b1; re = 1'b0; start = 1'b0; adress = a; in = d;
        tick();
        model[a] = d;
        chk("wr_valid", 32'(out_valid), 0);
    endtask

    task automatic single_read(input string tag, input logic [2:0] a, input logic [7:0] e);
        cs = 1'b1; we = 1'b0; re = 1'b1; start = 1'b0; adress = a;
        tick();
        chk(tag, 32'(out), 32'(e));
        chk({tag, "_v"}, 32'(out_valid), 1);
        chk({tag, "_pe"}, 32'(parity_err), 0);
    endtask

    initial begin
        int  beats;
        logic seen;

        reset = 1'b0; burst_len = '0; adress = '0; in = '0;
        idle();
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

        // reset state
        tick();
        chk("rst_out", 32'(out), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pe", 32'(parity_err), 0);
        reset = 1'b1;

        // reset clears every word
        for (int i = 0; i < DEPTH; i++) single_write(3'(i), 8'hAA);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) single_read("clr_rd", 3'(i), 8'h00);

        // single access
        single_write(3'd5, 8'h3C);
        single_read("rd5", 3'd5, 8'h3C);
        cs = 1'b1; re = 1'b1; we = 1'b1; adress = 3'd2; in = 8'h55;
        tick();
        model[2] = 8'h55;
        chk("rewe_valid", 32'(out_valid), 0);
        chk("rewe_hold", 32'(out), 32'h3C);
        single_read("rd2", 3'd2, 8'h55);
        cs = 1'b0; re = 1'b0; we = 1'b1; adress = 3'd2; in = 8'h99;
        tick();
        chk("cs0_hold", 32'(out), 32'h55);
        chk("cs0_valid", 32'(out_valid), 0);
        single_read("cs0_nowr", 3'd2, 8'h55);

        // write burst with wrap 6,7,0,1
        cs = 1'b1; we = 1'b1; re = 1'b0; start = 1'b1; adress = 3'd6; burst_len = 4'd4;
        tick();
        chk("wb_busy0", 32'(busy), 1);
        chk("wb_done0", 32'(done), 0);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in = 8'h11 + 8'(k);
            tick();
            chk("wb_busy", 32'(busy), (k < 3) ? 1 : 0);
            chk("wb_done", 32'(done), (k == 3) ? 1 : 0);
            chk("wb_valid", 32'(out_valid), 0);
        end
        model[6] = 8'h11; model[7] = 8'h12; model[0] = 8'h13; model[1] = 8'h14;
        idle();
        tick();
        chk("wb_done_pulse", 32'(done), 0);

        // read burst back, then back-to-back start on first idle cycle
        cs = 1'b1; we = 1'b0; start = 1'b1; adress = 3'd6; burst_len = 4'd4;
        tick();
        chk("rb_busy0", 32'(busy), 1);
        chk("rb_valid0", 32'(out_valid), 0);
        idle();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rb_data", 32'(out), 32'(8'h11 + 8'(k)));
            chk("rb_valid", 32'(out_valid), 1);
            chk("rb_done", 32'(done), (k == 3) ? 1 : 0);
        end
        cs = 1'b1; we = 1'b0; start = 1'b1; adress = 3'd5; burst_len = 4'd1;
        tick();
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_valid0", 32'(out_valid), 0);
        idle();
        tick();
        chk("b2b_data", 32'(out), 32'h3C);
        chk("b2b_done", 32'(done), 1);
        chk("b2b_busy_end", 32'(busy), 0);

        // burst_len 12 clamps to 8 beats
        cs = 1'b1; we = 1'b0; start = 1'b1; adress = 3'd0; burst_len = 4'd12;
        tick();
        idle();
        beats = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (out_valid) begin
                chk("clamp_data", 32'(out), 32'(model[beats % DEPTH]));
                beats++;
            end
            if (done) seen = 1'b1;
        end
        chk("clamp_done", 32'(seen), 1);
        chk("clamp_beats", 32'(beats), 8);

        // reset mid-burst; inputs toggled during the burst are ignored
        cs = 1'b1; we = 1'b0; start = 1'b1; adress = 3'd0; burst_len = 4'd8;
        tick();
        cs = 1'b0; start = 1'b1; we = 1'b1; adress = 3'd3; in = 8'hFF;
        tick();
        chk("ab_b1", 32'(out), 32'(model[0]));
        chk("ab_busy1", 32'(busy), 1);
        tick();
        chk("ab_b2", 32'(out), 32'(model[1]));
        chk("ab_valid2", 32'(out_valid), 1);
        reset = 1'b0;
        tick();
        chk("ab_busy", 32'(busy), 0);
        chk("ab_done", 32'(done), 0);
        chk("ab_out", 32'(out), 0);
        chk("ab_valid", 32'(out_valid), 0);
        reset = 1'b1;
        idle();
        tick();
        chk("ab_done_after", 32'(done), 0);
        chk("ab_busy_after", 32'(busy), 0);
        for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        for (int i = 0; i < DEPTH; i++) single_read("ab_clr", 3'(i), 8'h00);

`ifdef BURST_RAM_PARITY_EN
        single_write(3'd3, 8'h07);
        dut.par[3] = ~dut.par[3];
        cs = 1'b1; we = 1'b0; re = 1'b1; adress = 3'd3;
        tick();
        chk("par_out", 32'(out), 32'h07);
        chk("par_valid", 32'(out_valid), 1);
        chk("par_err", 32'(parity_err), 1);
        single_write(3'd5, 8'h01);
        single_read("par_clean", 3'd5, 8'h01);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
